// File: rtl/usr_pkg.sv
// Shared mode/state encodings and helpers for the universal shift register.
package usr_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } usr_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } usr_state_e;

   // Only movement modes make sense to repeat; anything else is stepped as hold.
   function automatic logic is_burst_mode(usr_mode_e m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
             (m == MODE_ROL) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value function of the shift register for one mode step.
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur_i,
   input  usr_mode_e        mode_i,
   input  logic             msb_in_i,
   input  logic             lsb_in_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] next_o
);

   always_comb begin
      next_o = cur_i;
      case (mode_i)
         MODE_HOLD: next_o = cur_i;
         MODE_SHR:  next_o = {msb_in_i, cur_i[WIDTH-1:1]};
         MODE_SHL:  next_o = {cur_i[WIDTH-2:0], lsb_in_i};
         MODE_LOAD: next_o = in_i;
         MODE_ROR:  next_o = {cur_i[0], cur_i[WIDTH-1:1]};
         MODE_ROL:  next_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
         MODE_ASR:  next_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
         MODE_CLR:  next_o = '0;
         default:   next_o = cur_i;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register with single-step modes and a counted burst engine.
module univ_shift_reg_n
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             en,
   input  logic [2:0]       sel_line,
   input  logic [WIDTH-1:0] in,
   input  logic             msb_in,
   input  logic             lsb_in,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] out,
   output logic             msb_out,
   output logic             lsb_out,
   output logic             busy,
   output logic             done
);

   usr_state_e       state_q, state_d;
   usr_mode_e        mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   usr_mode_e        step_mode;

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_HOLD;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   // The core always runs; HOLD is selected whenever the register must not change.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      step_mode = MODE_HOLD;
      case (state_q)
         ST_IDLE: begin
            if (burst_start) begin
               mode_d  = usr_mode_e'(sel_line);
               cnt_d   = burst_len;
               state_d = ST_RUN;
            end else if (en) begin
               step_mode = usr_mode_e'(sel_line);
            end
         end
         ST_RUN: begin
            if (cnt_q != '0) begin
               step_mode = is_burst_mode(mode_q) ? mode_q : MODE_HOLD;
               cnt_d     = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   usr_shift_core #(.WIDTH(WIDTH)) u_core (
      .cur_i    (out_q),
      .mode_i   (step_mode),
      .msb_in_i (msb_in),
      .lsb_in_i (lsb_in),
      .in_i     (in),
      .next_o   (out_d)
   );

   assign out     = out_q;
   assign msb_out = out_q[WIDTH-1];
   assign lsb_out = out_q[0];
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n (WIDTH=8) against an arithmetic reference model.
module tb_univ_shift_reg_n;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          Clear;
   logic          en;
   logic [2:0]    sel_line;
   logic [W-1:0]  din;
   logic          msb_in;
   logic          lsb_in;
   logic          burst_start;
   logic [CW-1:0] burst_len;
   logic [W-1:0]  out;
   logic          msb_out;
   logic          lsb_out;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] mout;

   univ_shift_reg_n #(.WIDTH(W)) dut (
      .CLK(CLK), .Clear(Clear), .en(en), .sel_line(sel_line), .in(din),
      .msb_in(msb_in), .lsb_in(lsb_in), .burst_start(burst_start),
      .burst_len(burst_len), .out(out), .msb_out(msb_out), .lsb_out(lsb_out),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   // Reference behaviour written with integer arithmetic on the register value.
   function automatic logic [W-1:0] ref_next(logic [W-1:0] cur, logic [2:0] m,
                                             logic mi, logic li, logic [W-1:0] d);
      int c;
      c = int'(cur);
      case (m)
         3'd1: return W'(c / 2 + (mi ? 128 : 0));
         3'd2: return W'((c * 2) % 256 + (li ? 1 : 0));
         3'd3: return d;
         3'd4: return W'(c / 2 + (c % 2) * 128);
         3'd5: return W'((c * 2) % 256 + c / 128);
         3'd6: return W'(c / 2 + ((c >= 128) ? 128 : 0));
         3'd7: return '0;
         default: return cur;
      endcase
   endfunction

   function automatic bit is_bm(logic [2:0] m);
      return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Clear = 1'b1; en = 0; sel_line = 0; din = 0; msb_in = 0; lsb_in = 0;
      burst_start = 0; burst_len = 0;
      #3;
      total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      @(posedge CLK); #1;
      Clear = 1'b0;
      mout = '0;
   endtask

   task automatic single(input logic [2:0] s, input logic e, input logic [W-1:0] d,
                         input logic mi, input logic li);
      sel_line = s; en = e; din = d; msb_in = mi; lsb_in = li; burst_start = 0;
      if (e) mout = ref_next(mout, s, mi, li, d);
      step();
   endtask

   task automatic test_load();
      single(3'b011, 1, 8'hB5, 0, 0);
      total++; if (out !== 8'hB5) begin bad++; $display("FAIL load_out got=%h exp=b5", out); end
      total++; if (lsb_out !== 1'b1) begin bad++; $display("FAIL load_lsb got=%b exp=1", lsb_out); end
      total++; if (msb_out !== 1'b1) begin bad++; $display("FAIL load_msb got=%b exp=1", msb_out); end
   endtask

   task automatic test_directed_modes();
      logic [2:0] s_t [10] = '{3'b001, 3'b010, 3'b001, 3'b011, 3'b101, 3'b011, 3'b110, 3'b011, 3'b111, 3'b100};
      logic       e_t [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
      logic [7:0] d_t [10] = '{8'h00, 8'h00, 8'h00, 8'hB5, 8'h00, 8'h96, 8'h00, 8'h96, 8'h00, 8'h00};
      logic       m_t [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      logic       l_t [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      logic [7:0] x_t [10] = '{8'hDA, 8'hB4, 8'hB4, 8'hB5, 8'h6B, 8'h96, 8'hCB, 8'h96, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) begin
         single(s_t[i], e_t[i], d_t[i], m_t[i], l_t[i]);
         total++;
         if (out !== x_t[i]) begin bad++; $display("FAIL mode_step%0d got=%h exp=%h", i, out, x_t[i]); end
      end
   endtask

   task automatic test_random_steps();
      for (int i = 0; i < 60; i++) begin
         single(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 8'($urandom),
                1'($urandom), 1'($urandom));
         total++;
         if (out !== mout || msb_out !== mout[7] || lsb_out !== mout[0]) begin
            bad++; $display("FAIL rand_step%0d got=%h exp=%h", i, out, mout);
         end
      end
   endtask

   // Runs one burst and checks data, busy and done on every cycle; noise inputs must be ignored.
   task automatic run_burst(input logic [2:0] m, input int len, input bit rnd_serial,
                            input logic mi, input logic li, input bit noise, output int busy_cnt,
                            output int done_cnt);
      busy_cnt = 0; done_cnt = 0;
      sel_line = m; burst_len = CW'(len); burst_start = 1; en = 1; din = 8'($urandom);
      msb_in = mi; lsb_in = li;
      step();
      busy_cnt += int'(busy); done_cnt += int'(done);
      total++; if (out !== mout || busy !== 1'b1) begin
         bad++; $display("FAIL burst_accept got=%h/%b exp=%h/1", out, busy, mout);
      end
      burst_start = 0;
      for (int i = 0; i <= len; i++) begin
         if (noise) begin
            sel_line = 3'($urandom); en = 1'($urandom); din = 8'($urandom);
            burst_start = 1'($urandom);
         end
         if (rnd_serial) begin msb_in = 1'($urandom); lsb_in = 1'($urandom); end
         if (i < len && is_bm(m)) mout = ref_next(mout, m, msb_in, lsb_in, din);
         step();
         busy_cnt += int'(busy); done_cnt += int'(done);
         total++;
         if (out !== mout || busy !== 1'b1 || done !== (i == len)) begin
            bad++;
            $display("FAIL burst_cycle%0d got=%h/%b/%b exp=%h/1/%b", i, out, busy, done, mout, i == len);
         end
      end
      burst_start = 0; en = 0;
      step();
      busy_cnt += int'(busy); done_cnt += int'(done);
      total++; if (busy !== 1'b0 || done !== 1'b0 || out !== mout) begin
         bad++; $display("FAIL burst_idle got=%h/%b/%b exp=%h/0/0", out, busy, done, mout);
      end
   endtask

   task automatic test_burst_rotate();
      int bc, dc;
      single(3'b011, 1, 8'h81, 0, 0);
      run_burst(3'b100, 3, 0, 0, 0, 1, bc, dc);
      total++; if (out !== 8'h30) begin bad++; $display("FAIL burst_ror_final got=%h exp=30", out); end
      total++; if (bc !== 5) begin bad++; $display("FAIL burst_ror_busy got=%0d exp=5", bc); end
      total++; if (dc !== 1) begin bad++; $display("FAIL burst_ror_done got=%0d exp=1", dc); end
   endtask

   task automatic test_burst_edges();
      int bc, dc;
      single(3'b011, 1, 8'h5A, 0, 0);
      run_burst(3'b001, 0, 0, 1, 1, 0, bc, dc);
      total++; if (bc !== 2 || dc !== 1 || out !== 8'h5A) begin
         bad++; $display("FAIL burst_len0 got=busy%0d/done%0d/%h exp=busy2/done1/5a", bc, dc, out);
      end
      single(3'b011, 1, 8'hFF, 0, 0);
      run_burst(3'b001, 12, 0, 0, 0, 0, bc, dc);
      total++; if (out !== 8'h00 || bc !== 14) begin
         bad++; $display("FAIL burst_over got=%h/busy%0d exp=00/busy14", out, bc);
      end
      single(3'b011, 1, 8'hC3, 0, 0);
      run_burst(3'b011, 4, 0, 0, 0, 1, bc, dc);
      total++; if (out !== 8'hC3 || bc !== 6) begin
         bad++; $display("FAIL burst_nonshift got=%h/busy%0d exp=c3/busy6", out, bc);
      end
   endtask

   task automatic test_back_to_back();
      int bc, dc;
      logic [2:0] m;
      for (int i = 0; i < 8; i++) begin
         single(3'b011, 1, 8'($urandom), 0, 0);
         m = 3'($urandom);
         run_burst(m, $urandom_range(0, 15), 1, 1'($urandom), 1'($urandom), 1, bc, dc);
         total++; if (dc !== 1) begin bad++; $display("FAIL b2b_done%0d got=%0d exp=1", i, dc); end
      end
   endtask

   task automatic test_reset_mid_burst();
      single(3'b011, 1, 8'hE7, 0, 0);
      sel_line = 3'b001; burst_len = 4'd5; burst_start = 1; msb_in = 1;
      step();
      burst_start = 0;
      step(); step();
      #2 Clear = 1'b1;
      #1;
      mout = '0;
      total++; if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL midreset got=%h/%b/%b exp=00/0/0", out, busy, done);
      end
      step();
      Clear = 1'b0;
      en = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h00) begin
            bad++; $display("FAIL midreset_after%0d got=%h/%b/%b exp=00/0/0", i, out, busy, done);
         end
      end
      single(3'b011, 1, 8'h3C, 0, 0);
      total++; if (out !== 8'h3C) begin bad++; $display("FAIL midreset_reload got=%h exp=3c", out); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_directed_modes();
      test_random_steps();
      test_burst_rotate();
      test_burst_edges();
      test_back_to_back();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
